fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage: reads the 16-bit instruction memory word by word and delivers complete instructions to decode through a one-entry output register with a valid/ready handshake. Opcodes with an immediate (LDM class, `IR[15:13] == IMM_OPCODE`) use two consecutive words: the opcode word, then the 16-bit immediate. The unit assembles both words into one output beat. It sits between the program counter / instruction memory read port and the IF/ID buffer, and replaces the free-running PC + raw-word path.

## Interface
- `RESET_PC`, default 32: PC value loaded on reset; the first program word lives here.
- `ADDR_W`, default 32: PC and memory address width.
- `IMM_OPCODE`, default 3'b001: value of `IR[15:13]` that marks a two-word (immediate) instruction.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_addr`  out  ADDR_W  instruction memory read address; always equal to the PC register.
- `mem_data`  in  16  instruction memory read data; combinational, valid in the same cycle as `mem_addr`.
- `redirect`  in  1  load `redirect_pc` into the PC and flush (branch/jump from later stages).
- `redirect_pc`  in  ADDR_W  new fetch address.
- `id_ready`  in  1  decode accepts the output beat this cycle.
- `if_valid`  out  1  output register holds a complete instruction.
- `if_instr`  out  16  opcode word.
- `if_imm`  out  16  immediate word; 0 for single-word instructions.
- `if_has_imm`  out  1  1 when `if_imm` is meaningful.
- `if_pc`  out  ADDR_W  address of the opcode word.

## Operation
- Registers: PC, state (S_OP / S_IMM), `op_hold` (16 b), `op_pc` (ADDR_W), and the output register (`if_valid`, `if_instr`, `if_imm`, `if_has_imm`, `if_pc`).
- `slot_free = !if_valid || id_ready`. A transfer to decode occurs when `if_valid && id_ready`.
- Reset: PC = RESET_PC, state = S_OP, `op_hold`/`op_pc` = 0, `if_valid` = 0, and all `if_*` data outputs = 0. `mem_addr` = RESET_PC.
- S_OP, `mem_data[15:13] == IMM_OPCODE`: `op_hold <= mem_data`, `op_pc <= PC`, PC += 1, go to S_IMM. The output register is not touched; a pending beat keeps following the handshake normally.
- S_OP, single-word instruction, `slot_free`: load the output register with `{valid=1, instr=mem_data, imm=0, has_imm=0, pc=PC}`, then PC += 1.
- S_OP, single-word instruction, `!slot_free`: stall. PC and state are held, and the same address is re-read next cycle.
- S_IMM, `slot_free`: load the output register with `{valid=1, instr=op_hold, imm=mem_data, has_imm=1, pc=op_pc}`, PC += 1, go to S_OP.
- S_IMM, `!slot_free`: stall and hold everything.
- Output register, no new load: if `id_ready` then `if_valid <= 0`, otherwise hold all outputs unchanged.
- Redirect has priority over all of the above except reset. On a redirect edge:
  - PC <= `redirect_pc`, state <= S_OP, `if_valid` <= 0.
  - Any half-assembled LDM is discarded.
  - A beat with `if_valid && id_ready` in the same cycle still counts as transferred.
- PC arithmetic is modulo 2^ADDR_W: PC 2^ADDR_W−1 increments to 0. A two-word instruction straddling the wrap takes its immediate from address 0.
- `mem_data` must never be sampled as an immediate across a redirect. Only S_IMM samples it as an immediate.

## Timing
- Single-word latency: the word is read in cycle N and `if_valid`/`if_instr` are visible in cycle N+1.
- Two-word latency: the opcode is read in N, the immediate in N+1, and the output is visible in N+2.
- Throughput with `id_ready` held high:
  - one single-word instruction per cycle;
  - one two-word instruction per 2 cycles.
  - No bubble when a load and a transfer occur in the same cycle.
- First fetch: the cycle in which `reset` is low after reset. The first output appears one cycle later (single-word).
- Redirect: `redirect` is asserted in cycle N. `mem_addr = redirect_pc` in N+1, and the first redirected instruction is valid in N+2 (single-word).
- While `if_valid && !id_ready`, every `if_*` output is stable. The unit never drops or duplicates an instruction.
- Reset asserted mid-operation (any state) restores all reset values at that edge. Partial assembly is discarded.

## Test plan
- Reset, memory[32]=0xA800 (NOP), `id_ready`=1 → cycle after the first fetch: `if_valid`=1, `if_instr`=0xA800, `if_has_imm`=0, `if_pc`=32; `mem_addr`=33.
- memory[32..33]=0x2800,0x000F (LDM R0,15), [34]=0x6900 → one beat with `if_instr`=0x2800, `if_imm`=0x000F, `if_has_imm`=1, `if_pc`=32. The next beat has `if_pc`=34 on the following cycle, with no extra bubble.
- Stream of NOPs with `id_ready` low for 3 cycles → outputs and `mem_addr` frozen. After release, `if_pc` values are consecutive with none skipped or repeated.
- Redirect to 80 in the cycle S_IMM is entered for the LDM at 32 → no beat with `if_pc`=32 ever appears, and the next beat has `if_pc`=80.
- Redirect to 0xFFFFFFFF, memory[0xFFFFFFFF]=0x2800, memory[0]=0x1234 → beat with `if_imm`=0x1234, `if_pc`=0xFFFFFFFF; next `mem_addr`=1.
- Assert `reset` while in S_IMM with `if_valid`=1 → next cycle: `if_valid`=0, `mem_addr`=32, state S_OP; refetch starts from 32.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: instruction memory read port, redirect request and the decode handshake.
// The master modport is the fetch unit; the slave modport is memory/decode/control.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_ready;
  logic              if_valid;
  logic [15:0]       if_instr;
  logic [15:0]       if_imm;
  logic              if_has_imm;
  logic [ADDR_W-1:0] if_pc;

  modport master (
    output mem_addr,
    input  mem_data,
    input  redirect,
    input  redirect_pc,
    input  id_ready,
    output if_valid,
    output if_instr,
    output if_imm,
    output if_has_imm,
    output if_pc
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    output redirect,
    output redirect_pc,
    output id_ready,
    input  if_valid,
    input  if_instr,
    input  if_imm,
    input  if_has_imm,
    input  if_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks instruction memory one word per cycle, joins two-word
// immediate instructions into a single beat and hands beats to decode via valid/ready.
module fetch_unit #(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32,
  parameter logic [2:0]      IMM_OPCODE = 3'b001
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  typedef enum logic {
    S_OP,
    S_IMM
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       opHold_q, opHold_d;
  logic [ADDR_W-1:0] opPc_q, opPc_d;
  logic              outValid_q, outValid_d;
  logic [15:0]       outInstr_q, outInstr_d;
  logic [15:0]       outImm_q, outImm_d;
  logic              outHasImm_q, outHasImm_d;
  logic [ADDR_W-1:0] outPc_q, outPc_d;

  logic slotFree;
  logic isImmOp;

  assign slotFree = !outValid_q || bus.id_ready;
  assign isImmOp  = (bus.mem_data[15:13] == IMM_OPCODE);

  // Next-state logic: a redirect overrides any fetch or assembly in progress, but the
  // output beat still transfers if decode accepts it in the same cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    opHold_d    = opHold_q;
    opPc_d      = opPc_q;
    outValid_d  = outValid_q;
    outInstr_d  = outInstr_q;
    outImm_d    = outImm_q;
    outHasImm_d = outHasImm_q;
    outPc_d     = outPc_q;

    if (bus.id_ready) begin
      outValid_d = 1'b0;
    end

    if (bus.redirect) begin
      pc_d       = bus.redirect_pc;
      state_d    = S_OP;
      outValid_d = 1'b0;
    end else begin
      case (state_q)
        S_OP: begin
          if (isImmOp) begin
            opHold_d = bus.mem_data;
            opPc_d   = pc_q;
            pc_d     = pc_q + ADDR_W'(1);
            state_d  = S_IMM;
          end else if (slotFree) begin
            outValid_d  = 1'b1;
            outInstr_d  = bus.mem_data;
            outImm_d    = 16'h0000;
            outHasImm_d = 1'b0;
            outPc_d     = pc_q;
            pc_d        = pc_q + ADDR_W'(1);
          end
        end
        S_IMM: begin
          if (slotFree) begin
            outValid_d  = 1'b1;
            outInstr_d  = opHold_q;
            outImm_d    = bus.mem_data;
            outHasImm_d = 1'b1;
            outPc_d     = opPc_q;
            pc_d        = pc_q + ADDR_W'(1);
            state_d     = S_OP;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OP;
      pc_q        <= RESET_PC;
      opHold_q    <= 16'h0000;
      opPc_q      <= '0;
      outValid_q  <= 1'b0;
      outInstr_q  <= 16'h0000;
      outImm_q    <= 16'h0000;
      outHasImm_q <= 1'b0;
      outPc_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      opHold_q    <= opHold_d;
      opPc_q      <= opPc_d;
      outValid_q  <= outValid_d;
      outInstr_q  <= outInstr_d;
      outImm_q    <= outImm_d;
      outHasImm_q <= outHasImm_d;
      outPc_q     <= outPc_d;
    end
  end

  assign bus.mem_addr   = pc_q;
  assign bus.if_valid   = outValid_q;
  assign bus.if_instr   = outInstr_q;
  assign bus.if_imm     = outImm_q;
  assign bus.if_has_imm = outHasImm_q;
  assign bus.if_pc      = outPc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run checked
// against a program-walking model of the instruction stream.
module tb_fetch_unit;

  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic        hasImm;
    logic [31:0] pc;
  } beat_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_unit #(
    .ADDR_W    (ADDR_W),
    .RESET_PC  (32'd32),
    .IMM_OPCODE(3'b001)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memory aliases on the low address byte so the wrap test can reach 0xFFFFFFFF.
  logic [15:0] memArr [256];
  int          memVersion = 0;

  always @(bus.mem_addr or memVersion) bus.mem_data = memArr[bus.mem_addr[7:0]];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic beat_t mkBeat(input logic [15:0] instr, input logic [15:0] imm,
                                   input logic hasImm, input logic [31:0] pc);
    beat_t b;
    b.instr  = instr;
    b.imm    = imm;
    b.hasImm = hasImm;
    b.pc     = pc;
    return b;
  endfunction

  function automatic beat_t currentBeat();
    return mkBeat(bus.if_instr, bus.if_imm, bus.if_has_imm, bus.if_pc);
  endfunction

  // Reference: the instruction that starts at address pc, decoded straight from memory.
  function automatic beat_t modelBeat(input logic [31:0] pc);
    logic [31:0] nxt;
    logic [15:0] word;
    nxt  = pc + 32'd1;
    word = memArr[pc[7:0]];
    if (word[15:13] == 3'b001) return mkBeat(word, memArr[nxt[7:0]], 1'b1, pc);
    return mkBeat(word, 16'h0000, 1'b0, pc);
  endfunction

  task automatic checkBeat(input string tag, input logic expValid, input beat_t expBeat);
    checkOutput(tag, 96'({bus.if_valid, currentBeat()}), 96'({expValid, expBeat}));
  endtask

  task automatic checkAddr(input string tag, input logic [31:0] expAddr);
    checkOutput(tag, 96'(bus.mem_addr), 96'(expAddr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeMem(input logic [31:0] a, input logic [15:0] w);
    memArr[a[7:0]] = w;
    memVersion++;
  endtask

  task automatic fillNops();
    for (int i = 0; i < 256; i++) memArr[i] = 16'hA800;
    memVersion++;
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic redir, input logic [31:0] rpc);
    reset           = r;
    bus.id_ready    = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    tick();
  endtask

  initial begin
    logic [31:0] modelPc;
    logic [31:0] rpc;
    logic        rdy, redir, held;
    logic [15:0] w;
    beat_t       expB;
    int          xfers;

    fillNops();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

    // Reset values, then a single NOP through the pipe
    tick();
    tick();
    checkBeat("rst_out", 1'b0, mkBeat(16'h0, 16'h0, 1'b0, 32'd0));
    checkAddr("rst_addr", 32'd32);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    checkBeat("nop_beat", 1'b1, mkBeat(16'hA800, 16'h0, 1'b0, 32'd32));
    checkAddr("nop_addr", 32'd33);

    // Two-word LDM followed by a single-word instruction with no bubble
    fillNops();
    writeMem(32'd32, 16'h2800);
    writeMem(32'd33, 16'h000F);
    writeMem(32'd34, 16'h6900);
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    checkBeat("ldm_gap", 1'b0, mkBeat(16'h0, 16'h0, 1'b0, 32'd0));
    checkAddr("ldm_addr1", 32'd33);
    tick();
    checkBeat("ldm_beat", 1'b1, mkBeat(16'h2800, 16'h000F, 1'b1, 32'd32));
    checkAddr("ldm_addr2", 32'd34);
    tick();
    checkBeat("ldm_next", 1'b1, mkBeat(16'h6900, 16'h0, 1'b0, 32'd34));

    // Backpressure: three cycles of id_ready low freeze everything
    fillNops();
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkBeat("stall_beat", 1'b1, mkBeat(16'hA800, 16'h0, 1'b0, 32'd32));
      checkAddr("stall_addr", 32'd33);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    checkBeat("release1", 1'b1, mkBeat(16'hA800, 16'h0, 1'b0, 32'd33));
    tick();
    checkBeat("release2", 1'b1, mkBeat(16'hA800, 16'h0, 1'b0, 32'd34));

    // Redirect while the LDM at 32 waits for its immediate
    fillNops();
    writeMem(32'd32, 16'h2800);
    writeMem(32'd33, 16'h000F);
    writeMem(32'd80, 16'h6980);
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd80);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkBeat("redir_drop", 1'b0, mkBeat(16'h0, 16'h0, 1'b0, 32'd0));
    checkAddr("redir_addr", 32'd80);
    tick();
    checkBeat("redir_beat", 1'b1, mkBeat(16'h6980, 16'h0, 1'b0, 32'd80));

    // LDM straddling the address wrap
    fillNops();
    writeMem(32'hFFFF_FFFF, 16'h2800);
    writeMem(32'd0, 16'h1234);
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkAddr("wrap_addr0", 32'hFFFF_FFFF);
    tick();
    checkAddr("wrap_addr1", 32'd0);
    checkBeat("wrap_gap", 1'b0, mkBeat(16'h0, 16'h0, 1'b0, 32'd0));
    tick();
    checkBeat("wrap_beat", 1'b1, mkBeat(16'h2800, 16'h1234, 1'b1, 32'hFFFF_FFFF));
    checkAddr("wrap_addr2", 32'd1);

    // Reset while assembling an LDM with a beat pending
    fillNops();
    writeMem(32'd33, 16'h2800);
    writeMem(32'd34, 16'h000F);
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checkBeat("mid_pending", 1'b1, mkBeat(16'hA800, 16'h0, 1'b0, 32'd32));
    checkAddr("mid_addr", 32'd34);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    checkBeat("mid_rst", 1'b0, mkBeat(16'h0, 16'h0, 1'b0, 32'd0));
    checkAddr("mid_rst_addr", 32'd32);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    checkBeat("mid_refetch", 1'b1, mkBeat(16'hA800, 16'h0, 1'b0, 32'd32));

    // Randomized program with random backpressure and occasional redirects
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[15:13] = 3'b001;
      else if (w[15:13] == 3'b001) w[15:13] = 3'b101;
      memArr[i] = w;
    end
    memVersion++;
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    modelPc = 32'd32;
    xfers   = 0;
    for (int c = 0; c < 400; c++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 24) == 0);
      rpc   = $urandom;
      applyStimulus(1'b0, rdy, redir, rpc);
      if (bus.if_valid && rdy) begin
        expB = modelBeat(modelPc);
        checkBeat("rnd_xfer", 1'b1, expB);
        modelPc = modelPc + (expB.hasImm ? 32'd2 : 32'd1);
        xfers++;
      end
      held = bus.if_valid && !rdy && !redir;
      if (redir) modelPc = rpc;
      tick();
      if (held) checkBeat("rnd_hold", 1'b1, modelBeat(modelPc));
    end
    checkOutput("rnd_progress", 96'(xfers >= 100), 96'(1'b1));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
